// File: rtl/shift_unit_seq.sv
// Sequential shifter: one bit per clock, logical/arithmetic/rotate, busy/done handshake.
// Optional sticky output enabled by defining SHIFT_STICKY_EN.
module shift_unit_seq #(
  parameter int WIDTH = 4,
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init,
  input  logic [WIDTH-1:0] data_in,
  input  logic [AMT_W-1:0] amount,
  input  logic             dir,
  input  logic [1:0]       mode,
`ifdef SHIFT_STICKY_EN
  output logic             sticky,
`endif
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [AMT_W-1:0] count_q, count_d;
  logic             dir_q, dir_d;
  logic [1:0]       mode_q, mode_d;
  logic             init_prev_q, init_prev_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef SHIFT_STICKY_EN
  logic             sticky_q, sticky_d;
`endif

  logic             start;
  logic             rot;
  logic             ari;
  logic             fill;
  logic             out_bit;
  logic [WIDTH-1:0] stepped;

  assign start = (state_q == IDLE) && init && !init_prev_q;
  assign rot   = (mode_q == 2'b10);
  assign ari   = (mode_q == 2'b01);

  // Single-position step; mode 11 falls through to logical.
  always_comb begin
    fill    = 1'b0;
    out_bit = 1'b0;
    stepped = result_q;
    if (dir_q) begin
      out_bit = result_q[WIDTH-1];
      fill    = rot ? result_q[WIDTH-1] : 1'b0;
      stepped = {result_q[WIDTH-2:0], fill};
    end else begin
      out_bit = result_q[0];
      if (rot)
        fill = result_q[0];
      else if (ari)
        fill = result_q[WIDTH-1];
      stepped = {fill, result_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    count_d     = count_q;
    dir_d       = dir_q;
    mode_d      = mode_q;
    init_prev_d = init;
`ifdef SHIFT_STICKY_EN
    sticky_d    = sticky_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          result_d = data_in;
          dir_d    = dir;
          mode_d   = mode;
          count_d  = amount;
`ifdef SHIFT_STICKY_EN
          sticky_d = 1'b0;
`endif
          state_d  = (amount != '0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        result_d = stepped;
        count_d  = count_q - AMT_W'(1);
`ifdef SHIFT_STICKY_EN
        sticky_d = sticky_q | (out_bit & !rot);
`endif
        if (count_q == AMT_W'(1))
          state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == SHIFT);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      result_q    <= '0;
      count_q     <= '0;
      dir_q       <= 1'b0;
      mode_q      <= 2'b00;
      init_prev_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef SHIFT_STICKY_EN
      sticky_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      count_q     <= count_d;
      dir_q       <= dir_d;
      mode_q      <= mode_d;
      init_prev_q <= init_prev_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef SHIFT_STICKY_EN
      sticky_q    <= sticky_d;
`endif
    end
  end

  assign result = result_q;
  assign busy   = busy_q;
  assign done   = done_q;
`ifdef SHIFT_STICKY_EN
  assign sticky = sticky_q;
`endif

endmodule

// File: doc/shift_unit_seq.md
Name: shift_unit_seq

Overview:
Parametrised sequential barrel-replacement shifter, the next generation of the 4-bit right-shift block in the ALU datapath. It loads an operand on a start pulse, then shifts one bit position per clock for a programmable amount. Direction and mode (logical / arithmetic / rotate) are selectable. A busy/done handshake lets the top-level ALU sequencer pick up the result.

Parameters:
WIDTH, 4, operand/result width in bits (>=2)
AMT_W, 3, width of shift-amount field; amounts 0..2^AMT_W-1 accepted

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-low (sampled on rising clk; rst=0 resets)
init  input  1  start request; pushbutton-style level, internally rising-edge detected
data_in  input  WIDTH  operand, sampled on accepted start
amount  input  AMT_W  number of single-bit shifts, sampled on accepted start
dir  input  1  0=right, 1=left, sampled on accepted start
mode  input  2  00 logical, 01 arithmetic, 10 rotate, 11 reserved (treated as logical)
result  output  WIDTH  shift register contents
busy  output  1  high while operation in progress (states SHIFT)
done  output  1  one-cycle pulse, result valid

Behaviour:
- Reset (rst=0 at clk edge): state=IDLE, result=0, count=0, busy=0, done=0, init edge-detector history=1 (an init already held high at reset release does not start).
- Start accepted when state=IDLE and init=1 and previous-cycle init=0; init edges in SHIFT or DONE ignored (no queuing).
- On accepted start: result<=data_in, latch dir/mode, count<=amount; next state SHIFT if amount!=0, else DONE.
- SHIFT: every cycle result shifted by one position, count decremented; when count==1 that cycle's shift is the last, next state DONE.
- DONE: done=1 for exactly one cycle, busy=0; next state IDLE. result holds until the next accepted start or reset.
- Latency: done high in the cycle after amount+1 rising edges following the start edge (amount=0 -> done after 1 edge).
- Per-step shift rules:
  - logical right: MSB fill 0; logical left: LSB fill 0.
  - arithmetic right: MSB fill = current MSB (sign); arithmetic left = logical left.
  - rotate right: MSB fill = old LSB; rotate left: LSB fill = old MSB.
  - mode 11: identical to logical.
- Amount >= WIDTH legal: logical -> all zeros; arithmetic right -> all sign bits; rotate -> effective amount mod WIDTH (performed naturally by stepping).
- Reset mid-operation: aborts immediately, all outputs to reset values, no done pulse.
- data_in/amount/dir/mode changes during SHIFT have no effect.

Optional Feature:
SHIFT_STICKY_EN: when defined, adds output port sticky (1 bit). Cleared on accepted start and reset; in logical/arithmetic modes set to 1 if any bit equal to 1 is shifted out (right: old LSB; left: old MSB); stays 0 in rotate mode; valid with done, held afterward. When undefined, port and logic absent; all other behaviour identical.

Test Plan:
WIDTH=4, logical right, data_in=0111, amount=1, init pulse -> busy 1 cycle, done next cycle, result=0011 (sticky=1 if enabled).
Arithmetic right, data_in=1000, amount=2 -> result 1100 then 1110; done 3 edges after start, result=1110.
Rotate left, data_in=1001, amount=5 -> result=0011 at done (5 mod 4 = 1).
amount=0, data_in=1010, any mode -> no SHIFT state, done 1 edge after start, result=1010, busy never high.
init held high 10 cycles after one op -> exactly one done pulse; second init edge while busy ignored.
rst=0 asserted mid-shift (logical left 0001, amount=3, after 1 step) -> result=0000, busy=0, no done; a new init edge afterwards runs normally.
